// File: rtl/digiac_pkg.sv
// Shared types and default timing constants for the 65C02 bus sequencer.
package digiac_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } seq_state_e;

  localparam int unsigned DIV_DEF       = 16;
  localparam int unsigned VIA_DIV_DEF   = 4;
  localparam int unsigned DMA_PHASE_DEF = 8;
  localparam int unsigned RAM_AW        = 13;

endpackage

// File: rtl/phase_gen.sv
// Frame phase counter with the free-running VIA enable and the trace phi2 strobe.
module phase_gen
  import digiac_pkg::*;
#(
  parameter int unsigned DIV     = DIV_DEF,
  parameter int unsigned VIA_DIV = VIA_DIV_DEF,
  parameter int unsigned PW      = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go_i,
  output logic [PW-1:0] ph_o,
  output logic          decide_o,
  output logic          via_clken_o,
  output logic          phi2_o
);

  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(DIV / 2 - 1);
  localparam logic [PW-1:0] VIA_MASK = PW'(VIA_DIV - 1);

  logic [PW-1:0] ph_q, ph_d;
  logic          via_q, via_d;
  logic          phi2_q, phi2_d;

  assign decide_o    = (ph_q == PH_LAST);
  assign ph_o        = ph_q;
  assign via_clken_o = via_q;
  assign phi2_o      = phi2_q;

  // phi2 rises with a granted CPU cycle and falls at mid-frame
  always_comb begin
    ph_d   = ph_q + PW'(1);
    via_d  = ((ph_d & VIA_MASK) == {PW{1'b0}});
    phi2_d = phi2_q;
    if (decide_o) begin
      phi2_d = go_i;
    end else if (ph_q == PH_HALF) begin
      phi2_d = 1'b0;
    end else begin
      phi2_d = phi2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q   <= {PW{1'b0}};
      via_q  <= 1'b0;
      phi2_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      via_q  <= via_d;
      phi2_q <= phi2_d;
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Bus timing, halt/single-step control and CPU/DMA sharing of the single RAM port.
module bus_sequencer
  import digiac_pkg::*;
#(
  parameter int unsigned DIV       = DIV_DEF,
  parameter int unsigned VIA_DIV   = VIA_DIV_DEF,
  parameter int unsigned DMA_PHASE = DMA_PHASE_DEF,
  parameter int unsigned AW        = RAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt_req,
  input  logic          step,
  input  logic          cpu_sync,
  output logic          cpu_clken,
  output logic          cpu_clken1,
  output logic          via_clken,
  output logic          phi2,
  output logic          halted,
  input  logic          cpu_ram_sel,
  input  logic          cpu_ram_we,
  input  logic [AW-1:0] cpu_ram_addr,
  input  logic [7:0]    cpu_ram_wdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  localparam int unsigned   PW     = $clog2(DIV);
  localparam logic [PW-1:0] DMA_PH = PW'(DMA_PHASE);

  logic [PW-1:0] ph_s;
  logic          decide_s;
  logic          go_s;
  seq_state_e    state_q, state_d;
  logic          step_pend_q, step_pend_d;
  logic          step_done_q, step_done_d;
  logic          clken_q, clken1_q;
  logic          dma_grant_s;
  logic          dma_p1_q, dma_rd_p1_q, dma_ack_q;
  logic [7:0]    dma_rdata_q, dma_rdata_d;

  phase_gen #(.DIV(DIV), .VIA_DIV(VIA_DIV), .PW(PW)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .go_i       (go_s),
    .ph_o       (ph_s),
    .decide_o   (decide_s),
    .via_clken_o(via_clken),
    .phi2_o     (phi2)
  );

  // frame decision: state only moves, and go only matters, at the last phase
  always_comb begin
    state_d = state_q;
    go_s    = 1'b0;
    if (decide_s) begin
      case (state_q)
        ST_RUN: begin
          if (halt_req && cpu_sync) begin
            state_d = ST_HALTED;
            go_s    = 1'b0;
          end else begin
            go_s    = 1'b1;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_d = ST_RUN;
            go_s    = 1'b1;
          end else if (step_pend_q || step) begin
            state_d = ST_STEP;
            go_s    = 1'b1;
          end else begin
            go_s    = 1'b0;
          end
        end
        ST_STEP: begin
          if (!halt_req) begin
            state_d = ST_RUN;
            go_s    = 1'b1;
          end else if (cpu_sync && step_done_q) begin
            state_d = ST_HALTED;
            go_s    = 1'b0;
          end else begin
            go_s    = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          go_s    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // step requests are only remembered while parked in HALTED
  always_comb begin
    step_pend_d = 1'b0;
    step_done_d = 1'b0;
    if ((state_q == ST_HALTED) && (state_d == ST_HALTED)) begin
      step_pend_d = step_pend_q | step;
    end else begin
      step_pend_d = 1'b0;
    end
    if (state_q == ST_STEP) begin
      step_done_d = step_done_q | clken_q;
    end else begin
      step_done_d = 1'b0;
    end
  end

  assign dma_grant_s = (ph_s == DMA_PH) && dma_req && !dma_p1_q && !dma_ack_q;

  always_comb begin
    dma_rdata_d = dma_rdata_q;
    if (dma_rd_p1_q) begin
      dma_rdata_d = ram_rdata;
    end else begin
      dma_rdata_d = dma_rdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      step_pend_q <= 1'b0;
      step_done_q <= 1'b0;
      clken_q     <= 1'b0;
      clken1_q    <= 1'b0;
      dma_p1_q    <= 1'b0;
      dma_rd_p1_q <= 1'b0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      step_done_q <= step_done_d;
      clken_q     <= go_s;
      clken1_q    <= clken_q;
      dma_p1_q    <= dma_grant_s;
      dma_rd_p1_q <= dma_grant_s & ~dma_we;
      dma_ack_q   <= dma_p1_q;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // CPU slot (phase 1) and DMA slot never coincide
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {AW{1'b0}};
    ram_wdata = 8'h00;
    if (clken1_q) begin
      ram_en    = 1'b1;
      ram_we    = cpu_ram_we & cpu_ram_sel;
      ram_addr  = cpu_ram_addr;
      ram_wdata = cpu_ram_wdata;
    end else if (dma_grant_s) begin
      ram_en    = 1'b1;
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else begin
      ram_en    = 1'b0;
    end
  end

  assign cpu_clken  = clken_q;
  assign cpu_clken1 = clken1_q;
  assign halted     = (state_q == ST_HALTED);
  assign dma_ack    = dma_ack_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized scoreboard bench for bus_sequencer with a frame-level reference model.
module tb_bus_sequencer;

  localparam int NF = 64;
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  logic        clk, reset;
  logic        halt_req, step, cpu_sync;
  logic        cpu_clken, cpu_clken1, via_clken, phi2, halted;
  logic        cpu_ram_sel, cpu_ram_we;
  logic [12:0] cpu_ram_addr;
  logic [7:0]  cpu_ram_wdata;
  logic        dma_req, dma_we;
  logic [12:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  bus_sequencer #(.DIV(16), .VIA_DIV(4), .DMA_PHASE(8), .AW(13)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .step(step), .cpu_sync(cpu_sync),
    .cpu_clken(cpu_clken), .cpu_clken1(cpu_clken1), .via_clken(via_clken), .phi2(phi2),
    .halted(halted), .cpu_ram_sel(cpu_ram_sel), .cpu_ram_we(cpu_ram_we),
    .cpu_ram_addr(cpu_ram_addr), .cpu_ram_wdata(cpu_ram_wdata), .dma_req(dma_req),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM behind the port, one-clock read latency
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // clock index since reset release
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic [7:0] data; } dma_exp_t;
  int       cpu_q[$];
  dma_exp_t dma_q[$];
  bit go_fr[0:NF], halted_fr[0:NF], cwe_fr[0:NF], den_fr[0:NF], dwe_fr[0:NF];
  bit mon_en;
  int errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic mon_sample();
    int p, fr;
    dma_exp_t e;
    p  = cyc % 16;
    fr = cyc / 16;
    if (fr > NF) fr = NF;
    if (cpu_clken) begin
      if (cpu_q.size() == 0) chk("cpu_clken_extra", 32'd1, 32'd0);
      else                   chk("cpu_clken_cycle", cyc, cpu_q.pop_front());
    end
    if (dma_ack) begin
      if (dma_q.size() == 0) chk("dma_ack_extra", 32'd1, 32'd0);
      else begin
        e = dma_q.pop_front();
        chk("dma_ack_cycle", cyc, e.cyc);
        chk("dma_rdata", dma_rdata, e.data);
      end
    end
    chk("cpu_clken1", cpu_clken1, go_fr[fr] && p == 1);
    chk("via_clken", via_clken, (p % 4 == 0) && cyc != 0);
    chk("phi2", phi2, go_fr[fr] && p < 8);
    chk("halted", halted, halted_fr[fr]);
    chk("ram_en", ram_en, (p == 1 && go_fr[fr]) || (p == 8 && den_fr[fr]));
    chk("ram_we", ram_we, (p == 1 && cwe_fr[fr]) || (p == 8 && dwe_fr[fr]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) mon_sample();
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_clken"}, cpu_clken, 1'b0);
    chk({tag, "_cpu_clken1"}, cpu_clken1, 1'b0);
    chk({tag, "_via_clken"}, via_clken, 1'b0);
    chk({tag, "_phi2"}, phi2, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_dma_ack"}, dma_ack, 1'b0);
    chk({tag, "_dma_rdata"}, dma_rdata, 8'h00);
    chk({tag, "_ram_en"}, ram_en, 1'b0);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
  endtask

  // reference memory over a 16-byte window so CPU and DMA collide often
  logic [7:0] refm [0:15];
  bit         refv [0:15];

  initial begin
    int mst, idx;
    bit pend, go, we;
    logic [7:0] last_rd, wd;
    dma_exp_t e;

    errors = 0; checks = 0; mon_en = 1'b0; reset = 1'b1;
    halt_req = 1'b0; step = 1'b0; cpu_sync = 1'b0;
    cpu_ram_sel = 1'b0; cpu_ram_we = 1'b0; cpu_ram_addr = 13'h0; cpu_ram_wdata = 8'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 13'h0; dma_wdata = 8'h0;
    for (int i = 0; i <= NF; i++) begin
      go_fr[i] = 1'b0; halted_fr[i] = 1'b0; cwe_fr[i] = 1'b0; den_fr[i] = 1'b0; dwe_fr[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin refm[i] = 8'h00; refv[i] = 1'b0; end
    mst = M_RUN; pend = 1'b0; last_rd = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    for (int f = 0; f < NF; f++) begin
      wait_cyc(16 * f + 2);
      if (f < 4) halt_req = 1'b0;
      else       halt_req = ($urandom_range(0, 3) != 0);
      cpu_sync      = 1'($urandom_range(0, 1));
      cpu_ram_sel   = (f != 0) && ($urandom_range(0, 3) != 0);
      cpu_ram_we    = 1'($urandom_range(0, 1));
      cpu_ram_addr  = 13'h1AB0 | 13'($urandom_range(0, 15));
      cpu_ram_wdata = 8'($urandom_range(0, 255));
      if (f == 1 || f == 2 || (f > 2 && $urandom_range(0, 3) != 0)) begin
        if (f == 1)      begin idx = 12; we = 1'b1; wd = 8'h5A; end
        else if (f == 2) begin idx = 12; we = 1'b0; wd = 8'h00; end
        else begin
          idx = $urandom_range(0, 15);
          we  = 1'($urandom_range(0, 1));
          wd  = 8'($urandom_range(0, 255));
        end
        if (!we && !refv[idx]) we = 1'b1;
        dma_req = 1'b1; dma_we = we; dma_addr = 13'h1AB0 | 13'(idx); dma_wdata = wd;
        den_fr[f] = 1'b1; dwe_fr[f] = we;
        if (we) begin refm[idx] = wd; refv[idx] = 1'b1; end
        else    last_rd = refm[idx];
        e.cyc = 16 * f + 10; e.data = last_rd;
        dma_q.push_back(e);
      end
      wait_cyc(16 * f + 5);
      if (f >= 4 && $urandom_range(0, 1) == 1) begin
        step = 1'b1;
        if (mst == M_HALT) pend = 1'b1;
      end
      wait_cyc(16 * f + 6);
      step = 1'b0;
      wait_cyc(16 * f + 10);
      dma_req = 1'b0;
      wait_cyc(16 * f + 15);
      go = 1'b1;
      if (mst == M_RUN) begin
        if (halt_req && cpu_sync) begin mst = M_HALT; go = 1'b0; pend = 1'b0; end
      end else if (mst == M_HALT) begin
        if (!halt_req)  mst = M_RUN;
        else if (pend)  begin mst = M_STEP; pend = 1'b0; end
        else            go = 1'b0;
      end else begin
        if (!halt_req)     mst = M_RUN;
        else if (cpu_sync) begin mst = M_HALT; go = 1'b0; pend = 1'b0; end
      end
      go_fr[f + 1]     = go;
      halted_fr[f + 1] = (mst == M_HALT);
      cwe_fr[f + 1]    = go && cpu_ram_sel && cpu_ram_we;
      if (go) cpu_q.push_back(16 * (f + 1));
      if (go && cpu_ram_sel && cpu_ram_we) begin
        refm[cpu_ram_addr[3:0]] = cpu_ram_wdata;
        refv[cpu_ram_addr[3:0]] = 1'b1;
      end
    end

    // DMA read in flight, then reset lands between access and ack
    wait_cyc(16 * NF + 2);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h1ABC;
    den_fr[NF] = 1'b1; dwe_fr[NF] = 1'b0;
    wait_cyc(16 * NF + 9);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    chk("dma_queue_drained", dma_q.size(), 0);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_dma_ack", dma_ack, 1'b0);
      chk("reset_ram_en", ram_en, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
